// File: rtl/uart_chunk_tx.sv
// rtl/uart_chunk_tx.sv - chunk serialiser feeding a UART TX byte interface
module uart_chunk_tx #(
  parameter int CHUNK_BYTES = 3,
  parameter int LEN_W       = 8,
  parameter int PREFIX_LEN  = 0,
  parameter int GAP_CYCLES  = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [CHUNK_BYTES*8-1:0] chunk_data,
  input  logic [LEN_W-1:0]         chunk_len,
  input  logic                     chunk_valid,
  output logic                     chunk_ready,
  output logic                     tx_dv,
  output logic [7:0]               tx_byte,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     chunk_done,
  output logic                     len_clamped,
  output logic [CNT_W-1:0]         chunk_count
);

  // One extra bit so that payload length plus the prefix byte never overflows.
  localparam int IDX_W = LEN_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(CHUNK_BYTES);
  localparam logic [IDX_W-1:0] PRE      = IDX_W'(PREFIX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CHUNK_BYTES*8-1:0] data_q, data_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [7:0]               byte_q, byte_d;
  logic                     clamp_q, clamp_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [LEN_W-1:0] eff_len;
  logic [IDX_W-1:0] total_new;
  logic [IDX_W-1:0] total_q;
  logic [IDX_W-1:0] pay_idx;
  logic [7:0]       pay_byte;
  logic             last_byte;

  // Effective length, sequence bookkeeping and payload byte selection.
  always_comb begin
    eff_len   = (chunk_len > MAX_LEN) ? MAX_LEN : chunk_len;
    total_new = {1'b0, eff_len} + PRE;
    total_q   = {1'b0, len_q} + PRE;
    last_byte = (idx_q == total_q - IDX_W'(1));
    // Sequence position minus the prefix slot gives the payload byte index.
    pay_idx   = idx_q - PRE;
    pay_byte  = '0;
    for (int i = 0; i < CHUNK_BYTES; i++) begin
      if (pay_idx == IDX_W'(i)) begin
        pay_byte = data_q[8*i +: 8];
      end
    end
  end

  // Next-state logic for the chunk sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    byte_d  = byte_q;
    clamp_d = clamp_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (chunk_valid) begin
          data_d = chunk_data;
          len_d  = eff_len;
          idx_d  = '0;
          if (chunk_len > MAX_LEN) begin
            clamp_d = 1'b1;
          end
          // An empty sequence skips straight to completion.
          state_d = (total_new == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if ((PREFIX_LEN != 0) && (idx_q == '0)) begin
          byte_d = 8'(len_q);
        end else begin
          byte_d = pay_byte;
        end
        state_d = S_TRIG;
      end
      S_TRIG: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (GAP_CYCLES > 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        count_d = count_q + CNT_W'(1);
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any chunk in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      byte_q  <= '0;
      clamp_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      clamp_q <= clamp_d;
      count_q <= count_d;
    end
  end

  assign chunk_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_dv       = (state_q == S_TRIG);
  assign chunk_done  = (state_q == S_DONE);
  assign tx_byte     = byte_q;
  assign len_clamped = clamp_q;
  assign chunk_count = count_q;

endmodule

// File: tb/tb_uart_chunk_tx.sv
// tb/tb_uart_chunk_tx.sv - self-checking bench for uart_chunk_tx
module tb_uart_chunk_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: 3-byte chunks, no prefix, no gap, 4-bit counter.
  // Index 1: 4-byte chunks, length prefix, 5-cycle gap, 16-bit counter.
  logic [31:0] cdata [2];
  logic [7:0]  clen [2];
  logic        cvalid [2];
  logic        spur [2];
  logic        resp_done [2];
  logic        cready [2];
  logic        txdv [2];
  logic [7:0]  txbyte [2];
  logic        busy [2];
  logic        cdone [2];
  logic        lclamp [2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  uart_chunk_tx #(.CHUNK_BYTES(3), .LEN_W(8), .PREFIX_LEN(0), .GAP_CYCLES(0), .CNT_W(4)) u_a (
    .CLK(clk), .RST_N(rst_n), .chunk_data(cdata[0][23:0]), .chunk_len(clen[0]),
    .chunk_valid(cvalid[0]), .chunk_ready(cready[0]), .tx_dv(txdv[0]), .tx_byte(txbyte[0]),
    .tx_done(resp_done[0] | spur[0]), .busy(busy[0]), .chunk_done(cdone[0]),
    .len_clamped(lclamp[0]), .chunk_count(cnt_a)
  );

  uart_chunk_tx #(.CHUNK_BYTES(4), .LEN_W(8), .PREFIX_LEN(1), .GAP_CYCLES(5), .CNT_W(16)) u_b (
    .CLK(clk), .RST_N(rst_n), .chunk_data(cdata[1]), .chunk_len(clen[1]),
    .chunk_valid(cvalid[1]), .chunk_ready(cready[1]), .tx_dv(txdv[1]), .tx_byte(txbyte[1]),
    .tx_done(resp_done[1] | spur[1]), .busy(busy[1]), .chunk_done(cdone[1]),
    .len_clamped(lclamp[1]), .chunk_count(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int resp_lat = 3;
  int ntxdv [2];
  int ndone [2];
  int exp_cnt [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  typedef struct {
    int          d;
    logic [31:0] data;
    logic [7:0]  len;
    bit          sp;
    int          n;
    logic [39:0] seq;
    logic        clamp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 5;
  endfunction

  task automatic qpush(input int d, input logic [7:0] b);
    if (d == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic qpop(input int d, output logic [7:0] b);
    if (d == 0) b = q0.pop_front();
    else b = q1.pop_front();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model and scoreboard: pops the expected byte on every tx_dv, checks
  // start latency against the last accept/tx_done, and answers with tx_done.
  initial begin
    int ref_cyc [2];
    int gap_ref [2];
    int cdown [2];
    logic [7:0] b;
    for (int d = 0; d < 2; d++) begin
      ref_cyc[d] = 0; gap_ref[d] = 0; cdown[d] = 0; resp_done[d] = 1'b0;
      ntxdv[d] = 0; ndone[d] = 0;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          cdown[d] = 0;
          resp_done[d] = 1'b0;
          if (d == 0) q0.delete();
          else q1.delete();
        end else begin
          resp_done[d] = 1'b0;
          if (cvalid[d] && cready[d]) begin
            ref_cyc[d] = cyc;
            gap_ref[d] = 0;
          end
          if (cdown[d] > 0) begin
            cdown[d]--;
            if (cdown[d] == 0) begin
              resp_done[d] = 1'b1;
              ref_cyc[d] = cyc;
              gap_ref[d] = gap_of(d);
            end
          end
          if (txdv[d]) begin
            ntxdv[d]++;
            chk("tx_dv_expected", qsize(d) > 0, 1);
            if (qsize(d) > 0) begin
              qpop(d, b);
              chk("tx_byte", txbyte[d], b);
            end
            chk("tx_dv_latency", cyc - ref_cyc[d], 2 + gap_ref[d]);
            cdown[d] = resp_lat;
          end
          if (cdone[d]) begin
            ndone[d]++;
            chk("chunk_done_latency", cyc - ref_cyc[d], 1);
            chk("bytes_left_at_done", qsize(d), 0);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [31:0] data, input logic [7:0] len, input bit sp,
                      input int n, input logic [39:0] seq, input logic clamp);
    logic [39:0] s;
    int k;
    bit bad;
    s = seq;
    for (int i = 0; i < n; i++) qpush(d, s[8*i +: 8]);
    @(negedge clk);
    cdata[d] = data; clen[d] = len; cvalid[d] = 1'b1;
    k = 0;
    while (!cready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_accept", cready[d], 1);
    if (sp) spur[d] = 1'b1;
    @(negedge clk);
    // Keep offering a different chunk while busy; it must not be taken.
    cdata[d] = ~data; clen[d] = len ^ 8'h5a;
    chk("busy_after_accept", busy[d], 1);
    bad = 1'b0;
    k = 1;
    while (!cdone[d] && k < 400) begin
      if (cready[d]) bad = 1'b1;
      if (k == 3) spur[d] = 1'b0;
      @(negedge clk);
      k++;
    end
    spur[d] = 1'b0;
    chk("chunk_done_seen", cdone[d], 1);
    chk("no_ready_while_busy", bad, 0);
    cvalid[d] = 1'b0;
    exp_cnt[d] = (exp_cnt[d] + 1) & ((d == 0) ? 32'hf : 32'hffff);
    @(negedge clk);
    chk("ready_after_done", cready[d], 1);
    chk("busy_after_done", busy[d], 0);
    chk("done_one_cycle", cdone[d], 0);
    chk("len_clamped", lclamp[d], clamp);
    chk("chunk_count", (d == 0) ? {28'd0, cnt_a} : {16'd0, cnt_b}, exp_cnt[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int base_tx, base_done, k;
    tbl[0]  = '{0, 32'h00030201, 8'd3,   1'b1, 3, 40'h0000030201, 1'b0};
    tbl[1]  = '{0, 32'h00c0ffee, 8'd2,   1'b0, 2, 40'h000000ffee, 1'b0};
    tbl[2]  = '{0, 32'h00123456, 8'd1,   1'b0, 1, 40'h0000000056, 1'b0};
    tbl[3]  = '{0, 32'h00a1b2c3, 8'd7,   1'b0, 3, 40'h0000a1b2c3, 1'b1};
    tbl[4]  = '{0, 32'h00999999, 8'd0,   1'b0, 0, 40'h0000000000, 1'b1};
    tbl[5]  = '{0, 32'h000a0b0c, 8'd3,   1'b0, 3, 40'h00000a0b0c, 1'b1};
    tbl[6]  = '{1, 32'hddccbbaa, 8'd2,   1'b1, 3, 40'h0000bbaa02, 1'b0};
    tbl[7]  = '{1, 32'h44332211, 8'd4,   1'b0, 5, 40'h4433221104, 1'b0};
    tbl[8]  = '{1, 32'h55555555, 8'd0,   1'b0, 1, 40'h0000000000, 1'b0};
    tbl[9]  = '{1, 32'h87654321, 8'd9,   1'b0, 5, 40'h8765432104, 1'b1};
    tbl[10] = '{1, 32'h01020304, 8'd255, 1'b0, 5, 40'h0102030404, 1'b1};

    for (int d = 0; d < 2; d++) begin
      cdata[d] = '0; clen[d] = '0; cvalid[d] = 1'b0; spur[d] = 1'b0; exp_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", cready[d], 1);
      chk("rst_busy", busy[d], 0);
      chk("rst_tx_dv", txdv[d], 0);
      chk("rst_tx_byte", txbyte[d], 0);
      chk("rst_chunk_done", cdone[d], 0);
      chk("rst_len_clamped", lclamp[d], 0);
    end
    chk("rst_count_a", cnt_a, 0);
    chk("rst_count_b", cnt_b, 0);

    // Stray tx_done while idle must not start anything.
    base_tx = ntxdv[0];
    spur[0] = 1'b1;
    repeat (3) @(negedge clk);
    spur[0] = 1'b0;
    @(negedge clk);
    chk("idle_spur_ready", cready[0], 1);
    chk("idle_spur_busy", busy[0], 0);
    chk("idle_spur_no_tx", ntxdv[0] - base_tx, 0);

    for (int i = 0; i < 11; i++) begin
      resp_lat = (i % 2 == 0) ? 3 : 1;
      send(tbl[i].d, tbl[i].data, tbl[i].len, tbl[i].sp, tbl[i].n, tbl[i].seq, tbl[i].clamp);
    end

    // Reset while waiting for the second byte's tx_done.
    resp_lat = 12;
    base_tx = ntxdv[0];
    qpush(0, 8'h01); qpush(0, 8'h02); qpush(0, 8'h03);
    @(negedge clk);
    cdata[0] = 32'h00030201; clen[0] = 8'd3; cvalid[0] = 1'b1;
    @(negedge clk);
    cvalid[0] = 1'b0;
    k = 0;
    while (ntxdv[0] - base_tx < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("second_byte_started", ntxdv[0] - base_tx, 2);
    @(negedge clk);
    base_done = ndone[0];
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", cready[0], 1);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_tx_dv", txdv[0], 0);
    chk("async_rst_tx_byte", txbyte[0], 0);
    chk("async_rst_done", cdone[0], 0);
    chk("async_rst_clamp_a", lclamp[0], 0);
    chk("async_rst_clamp_b", lclamp[1], 0);
    chk("async_rst_count_b", cnt_b, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    base_tx = ntxdv[0];
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", ndone[0] - base_done, 0);
    chk("no_tx_after_abort", ntxdv[0] - base_tx, 0);
    resp_lat = 3;
    send(0, 32'h000a0b0c, 8'd3, 1'b0, 3, 40'h00000a0b0c, 1'b0);
    send(1, 32'hddccbbaa, 8'd3, 1'b0, 4, 40'h00ccbbaa03, 1'b0);

    // Fifteen empty chunks take the 4-bit counter from 1 through 15 back to 0.
    for (int i = 0; i < 15; i++) begin
      send(0, 32'h00777777, 8'd0, 1'b0, 0, 40'h0, 1'b0);
    end
    chk("count_wrapped", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_chunk_tx.md
Name: uart_chunk_tx

Overview:
Parametrised chunk serialiser. It accepts a chunk of up to CHUNK_BYTES bytes, together with a byte count, over a valid/ready handshake. It then feeds the bytes one at a time to the UART TX byte interface (DV pulse in, done pulse back). It sits between frame/telemetry producers and the UART TX instance. Compared with the earlier hardwired chunk sender it adds configurable depth, an optional length-prefix byte, an optional inter-byte gap, length clamping and status counters.

Parameters:
CHUNK_BYTES, 3, maximum bytes per chunk (1..255)
LEN_W, 8, width of chunk_len; must satisfy 2^LEN_W > CHUNK_BYTES
PREFIX_LEN, 0, 1 = transmit the effective length as one byte before the payload
GAP_CYCLES, 0, idle clock cycles inserted after each tx_done before the next byte is loaded
CNT_W, 16, width of the chunk_count status counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
chunk_data  in  CHUNK_BYTES*8  payload; byte i = bits [8i+7:8i]
chunk_len  in  LEN_W  number of payload bytes to send
chunk_valid  in  1  producer has a chunk
chunk_ready  out  1  block can accept a chunk
tx_dv  out  1  one-cycle start pulse to UART TX
tx_byte  out  8  byte to UART TX
tx_done  in  1  UART TX finished byte (one-cycle pulse)
busy  out  1  high from accept until chunk_done
chunk_done  out  1  one-cycle pulse when the last byte's tx_done is received
len_clamped  out  1  sticky flag: a chunk_len > CHUNK_BYTES was accepted
chunk_count  out  CNT_W  chunks completed, wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - state=IDLE; chunk_ready=1; tx_dv=0; tx_byte=0; busy=0; chunk_done=0; len_clamped=0; chunk_count=0; internal index/gap counters=0.
  - Reset mid-chunk aborts the chunk without a completion pulse. Any UART byte already started is not recalled.
- Accept:
  - Occurs on the edge where chunk_valid && chunk_ready.
  - chunk_data is registered whole; the producer may change it afterwards.
  - Effective length L = min(chunk_len, CHUNK_BYTES). If chunk_len > CHUNK_BYTES, len_clamped is set; it is cleared only by reset.
  - chunk_ready=0 and busy=1 from the accept edge until return to IDLE.
- Transmission: total bytes T = L + PREFIX_LEN. If T==0, go to DONE directly: chunk_done pulses 1 cycle after accept, and tx_dv never fires.
- States:
  - IDLE: chunk_ready=1; on accept go to LOAD.
  - LOAD: tx_byte <= (byte 0 of the sequence is the prefix if PREFIX_LEN, else payload[idx]); go to TRIG.
  - TRIG: tx_dv=1 for exactly this cycle; go to WAIT.
  - WAIT: on tx_done:
    - if last byte, go to DONE;
    - else idx+1, then go to GAP if GAP_CYCLES>0, else to LOAD.
  - GAP: count GAP_CYCLES cycles, then go to LOAD.
  - DONE: chunk_done=1 for one cycle; chunk_count+1; idx=0; go to IDLE.
- Timing:
  - The first tx_dv is asserted 2 cycles after the accept edge.
  - The next tx_dv is asserted 2 + GAP_CYCLES cycles after the tx_done edge.
  - tx_byte is stable from LOAD until the following LOAD.
- Byte order: prefix (value L, zero-extended/truncated to 8 bits), then payload byte 0 up to byte L-1, lowest byte first.
- tx_done is ignored in all states except WAIT. chunk_valid is ignored while busy; it is never dropped silently, because the producer holds it until ready.
- IDLE and accept in the same cycle as chunk_done: not possible. DONE→IDLE costs one cycle, and chunk_ready re-asserts the cycle after chunk_done.
- chunk_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
1. Reset, then default params: chunk_data=0x030201, len=3 → tx_byte 0x01, 0x02, 0x03 in order; each tx_dv 2 cycles after accept/tx_done; chunk_done once; chunk_count=1.
2. PREFIX_LEN=1, CHUNK_BYTES=4, len=2, data=0xDDCCBBAA → bytes 0x02, 0xAA, 0xBB; len_clamped=0.
3. len=7 with CHUNK_BYTES=3 → exactly 3 bytes sent; len_clamped=1 and stays 1 across later chunks until reset. len=0, PREFIX_LEN=0 → no tx_dv; chunk_done 1 cycle after accept.
4. GAP_CYCLES=5 → tx_dv exactly 7 cycles after each non-final tx_done. Spurious tx_done in IDLE/LOAD/TRIG → no state change.
5. chunk_valid held high with changing data while busy → no second accept until the cycle after chunk_done. Data captured at accept is transmitted even if the input changes.
6. Assert RST_N low during WAIT of byte 2 → all outputs reach reset values immediately (asynchronous); no chunk_done. After release, a new chunk transmits correctly from byte 0. Run 65536 chunks with CNT_W=16 → chunk_count wraps to 0.
